// File: rtl/pwm_dimmer_top.sv
// LED dimmer: 4-bit duty code drives a 15-step PWM output and is echoed as a
// decimal 0..15 on a two-digit scan of a multiplexed seven-segment display.
module pwm_dimmer_top #(
    parameter int unsigned PWM_PRESCALE = 1,
    parameter int unsigned REFRESH_DIV  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] duty_cycle,
    output logic       pwm,
    output logic [3:0] an,
    output logic [7:0] sevenSegData
);

    localparam int unsigned PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_PRESCALE - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [3:0] CNT_LAST = 4'd14;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_TENS = 4'b1101;

    typedef enum logic {
        SCAN_ONES = 1'b0,
        SCAN_TENS = 1'b1
    } scan_e;

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [REF_W-1:0] refresh_q, refresh_d;
    logic [3:0]       pwm_cnt_q, pwm_cnt_d;
    logic [3:0]       duty_q, duty_d;
    logic             pwm_q, pwm_d;
    scan_e            scan_q, scan_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;

    logic             tick_c;
    logic             refresh_wrap_c;
    logic [3:0]       ones_c;
    logic             tens_c;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a} for one decimal digit.
    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Prescaler: one tick on the last clock of every PWM_PRESCALE clocks.
    always_comb begin
        tick_c  = (presc_q == PRE_LAST);
        presc_d = tick_c ? '0 : presc_q + PRE_W'(1);
    end

    // PWM counter 0..14; the duty code is latched only at the period boundary.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q;
        duty_d    = duty_q;
        if (tick_c) begin
            if (pwm_cnt_q == CNT_LAST) begin
                pwm_cnt_d = 4'd0;
                duty_d    = duty_cycle;
            end else begin
                pwm_cnt_d = pwm_cnt_q + 4'd1;
            end
        end
        // Evaluated on next-state values so the registered output tracks the counter exactly.
        pwm_d = (pwm_cnt_d < duty_d);
    end

    // Display refresh timebase.
    always_comb begin
        refresh_wrap_c = (refresh_q == REF_LAST);
        refresh_d      = refresh_wrap_c ? '0 : refresh_q + REF_W'(1);
    end

    // Decimal split of the latched duty code so the display always matches the LED.
    always_comb begin
        tens_c = (duty_d >= 4'd10);
        ones_c = tens_c ? (duty_d - 4'd10) : duty_d;
    end

    // Digit scan FSM; anode and segment registers load together.
    always_comb begin
        scan_d = scan_q;
        an_d   = AN_OFF;
        seg_d  = SEG_BLANK;
        if (refresh_wrap_c) begin
            scan_d = (scan_q == SCAN_ONES) ? SCAN_TENS : SCAN_ONES;
        end
        case (scan_d)
            SCAN_ONES: begin
                an_d  = AN_ONES;
                seg_d = seg_encode(ones_c);
            end
            SCAN_TENS: begin
                an_d  = AN_TENS;
                seg_d = tens_c ? seg_encode(4'd1) : SEG_BLANK;
            end
            default: begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q   <= '0;
            refresh_q <= '0;
            pwm_cnt_q <= 4'd0;
            duty_q    <= 4'd0;
            pwm_q     <= 1'b0;
            scan_q    <= SCAN_ONES;
            an_q      <= AN_OFF;
            seg_q     <= SEG_BLANK;
        end else begin
            presc_q   <= presc_d;
            refresh_q <= refresh_d;
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
            scan_q    <= scan_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign pwm          = pwm_q;
    assign an           = an_q;
    assign sevenSegData = seg_q;

endmodule

// File: tb/tb_pwm_dimmer_top.sv
// Directed bench for pwm_dimmer_top: reset hold, duty steps 0/3/14/15/0/7,
// period boundary latency, display scan and mid-period reset.
module tb_pwm_dimmer_top;

    logic       clk;
    logic       reset;
    logic [3:0] duty_cycle;
    logic       pwm;
    logic [3:0] an;
    logic [7:0] sevenSegData;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_duty = 0;
    int highs;

    logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    pwm_dimmer_top #(
        .PWM_PRESCALE(1),
        .REFRESH_DIV (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .duty_cycle  (duty_cycle),
        .pwm         (pwm),
        .an          (an),
        .sevenSegData(sevenSegData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pwm"}, {7'd0, pwm}, 8'h00);
        chk({tag, "_an"},  {4'd0, an}, 8'h0F);
        chk({tag, "_seg"}, sevenSegData, 8'hFF);
    endtask

    // Advance n clocks after reset release, checking every output against the expected waveform.
    task automatic run(input int n, output int hi);
        logic       exp_pwm;
        logic       exp_scan;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc % 15 == 0) exp_duty = int'(duty_cycle);
            exp_pwm  = ((cyc % 15) < exp_duty);
            exp_scan = (((cyc / 16) % 2) == 1);
            exp_an   = exp_scan ? 4'b1101 : 4'b1110;
            if (exp_scan) exp_seg = (exp_duty >= 10) ? 8'hF9 : 8'hFF;
            else          exp_seg = seg_tab[exp_duty % 10];
            if (pwm === 1'b1) hi++;
            chk("pwm", {7'd0, pwm}, {7'd0, exp_pwm});
            chk("an",  {4'd0, an}, {4'd0, exp_an});
            chk("seg", sevenSegData, exp_seg);
        end
    endtask

    initial begin
        reset      = 1'b0;
        duty_cycle = 4'b0111;

        // Reset held: outputs stay at reset values whatever duty_cycle does.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 3) duty_cycle = 4'b1111;
            chk_reset_outputs("rst_hold");
        end

        duty_cycle = 4'd0;
        reset      = 1'b1;
        cyc        = 0;
        exp_duty   = 0;

        // Duty 0 for 100 clocks: LED off, display "0" with tens blank.
        run(100, highs);
        chk("hi0", 8'(highs), 8'd0);

        // Duty 3: change at cyc 100 takes effect at boundary 105.
        duty_cycle = 4'd3;
        run(4, highs);
        chk("pre_boundary_3", 8'(highs), 8'd0);
        run(1, highs);
        chk("boundary_105", {7'd0, pwm}, 8'd1);
        run(45, highs);
        run(15, highs);
        chk("hi3", 8'(highs), 8'd3);

        // Duty 14: high 14, low 1; display shows "14".
        duty_cycle = 4'd14;
        run(30, highs);
        run(15, highs);
        chk("hi14", 8'(highs), 8'd14);
        run(32, highs);

        // Duty 15: constant high; display "15".
        duty_cycle = 4'd15;
        run(30, highs);
        run(34, highs);
        chk("hi15", 8'(highs), 8'd34);

        // Mid-period drop to 0 stays ignored until the next boundary.
        while (cyc % 15 != 4) run(1, highs);
        duty_cycle = 4'd0;
        run(10, highs);
        chk("mid_change_held", 8'(highs), 8'd10);
        run(1, highs);
        chk("boundary_zero", {7'd0, pwm}, 8'd0);
        run(30, highs);
        chk("hi0_after15", 8'(highs), 8'd0);

        // Duty 7, then reset pulse while pwm is high mid-period.
        duty_cycle = 4'd7;
        run(30, highs);
        while (cyc % 15 != 5) run(1, highs);
        chk("pre_reset_pwm", {7'd0, pwm}, 8'd1);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        chk_reset_outputs("rst_pulse");
        reset    = 1'b1;
        cyc      = 0;
        exp_duty = 0;

        // Restart with duty_q=0: low for 14 clocks, first high at boundary 15.
        run(14, highs);
        chk("post_rst_low", 8'(highs), 8'd0);
        run(1, highs);
        chk("post_rst_boundary", {7'd0, pwm}, 8'd1);
        run(30, highs);
        chk("hi7_x2", 8'(highs), 8'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
